// File: rtl/cronometro_pkg.sv
// Shared definitions for the multimode stopwatch: keypad codes, mode encoding
// and the BCD to seven-segment decoder.
package cronometro_pkg;

    localparam logic [4:0] T_0    = 5'd0;
    localparam logic [4:0] T_1    = 5'd1;
    localparam logic [4:0] T_2    = 5'd2;
    localparam logic [4:0] T_3    = 5'd3;
    localparam logic [4:0] T_4    = 5'd4;
    localparam logic [4:0] T_5    = 5'd5;
    localparam logic [4:0] T_6    = 5'd6;
    localparam logic [4:0] T_7    = 5'd7;
    localparam logic [4:0] T_8    = 5'd8;
    localparam logic [4:0] T_9    = 5'd9;
    localparam logic [4:0] T_A    = 5'd10;
    localparam logic [4:0] T_B    = 5'd11;
    localparam logic [4:0] T_C    = 5'd12;
    localparam logic [4:0] T_D    = 5'd13;
    localparam logic [4:0] T_ASTE = 5'd14;
    localparam logic [4:0] T_HASH = 5'd15;
    localparam logic [4:0] T_NULL = 5'd31;

    typedef enum logic [1:0] {
        UP   = 2'd0,
        SET  = 2'd1,
        DOWN = 2'd2
    } modo_t;

    // Active-high pattern, bit 0 = segment a ... bit 6 = segment g.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] pat;
        case (d)
            4'd0:    pat = 7'h3F;
            4'd1:    pat = 7'h06;
            4'd2:    pat = 7'h5B;
            4'd3:    pat = 7'h4F;
            4'd4:    pat = 7'h66;
            4'd5:    pat = 7'h6D;
            4'd6:    pat = 7'h7D;
            4'd7:    pat = 7'h07;
            4'd8:    pat = 7'h7F;
            4'd9:    pat = 7'h6F;
            default: pat = 7'h00;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/cronometro_multimodo_bcd_digito.sv
// One BCD digit of the counter: parallel load, increment or decrement when the
// tick reaches it through the carry/borrow chain.
module bcd_digito (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       tick,
    input  logic       up,
    input  logic       carry_in,
    output logic [3:0] q,
    output logic       carry_out
);

    logic [3:0] digit_reg;
    logic [3:0] digit_next;
    logic       at_limit;

    // Limit is 9 when counting up, 0 when counting down.
    assign at_limit  = up ? (digit_reg == 4'd9) : (digit_reg == 4'd0);
    assign carry_out = carry_in && at_limit;
    assign q         = digit_reg;

    always_comb begin
        digit_next = digit_reg;
        if (load) begin
            digit_next = load_val;
        end else if (tick && carry_in) begin
            if (up) begin
                digit_next = at_limit ? 4'd0 : digit_reg + 4'd1;
            end else begin
                digit_next = at_limit ? 4'd9 : digit_reg - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digit_reg <= 4'd0;
        end else begin
            digit_reg <= digit_next;
        end
    end

endmodule

// File: rtl/cronometro_multimodo.sv
// Keypad-driven N_DIG-digit BCD stopwatch / countdown timer with lap hold,
// preset entry and direct seven-segment drive.
module cronometro_multimodo
    import cronometro_pkg::*;
#(
    parameter int CLK_HZ      = 1000,
    parameter int TICK_HZ     = 10,
    parameter int N_DIG       = 4,
    parameter int SEG_ACT_LOW = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         key,
    output logic [4*N_DIG-1:0] bcd,
    output logic [7*N_DIG-1:0] seg,
    output logic [1:0]         modo,
    output logic               running,
    output logic               lap_hold,
    output logic               alarm
);

    localparam int W   = 4 * N_DIG;
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
    localparam logic [W-1:0]  COUNT_ONE = W'(1);

    logic [4:0]    k_q_reg;
    logic [4:0]    k_prev_reg;
    modo_t         mode_reg, mode_next;
    logic          running_reg, running_next;
    logic          lap_hold_reg, lap_hold_next;
    logic          alarm_reg, alarm_next;
    logic [W-1:0]  preset_reg, preset_next;
    logic [W-1:0]  lap_reg, lap_next;
    logic [PW-1:0] presc_reg, presc_next;
    logic [W-1:0]  bcd_reg, bcd_next;

    logic          press;
    logic          tick;
    logic          apply_tick;
    logic          count_load;
    logic [W-1:0]  count_load_val;
    logic          count_step;
    logic          count_up;
    logic          count_zero_dn;
    logic [W-1:0]  count_vec;
    logic [N_DIG:0] carry;

    // Codes 16..30 and T_NULL all have bit 4 set: never a press.
    assign press = (k_prev_reg == T_NULL) && (k_q_reg[4] == 1'b0);
    assign tick  = running_reg && (presc_reg == PRESC_MAX);

    always_comb begin
        mode_next      = mode_reg;
        running_next   = running_reg;
        lap_hold_next  = lap_hold_reg;
        alarm_next     = alarm_reg;
        preset_next    = preset_reg;
        lap_next       = lap_reg;
        presc_next     = presc_reg;
        apply_tick     = tick;
        count_load     = 1'b0;
        count_load_val = '0;

        if (running_reg) begin
            presc_next = tick ? '0 : presc_reg + 1'b1;
        end

        if (press) begin
            if (alarm_reg) begin
                alarm_next = 1'b0;
            end else begin
                case (mode_reg)
                    UP: begin
                        case (k_q_reg)
                            T_A: begin
                                if (running_reg) begin
                                    running_next = 1'b0;
                                    apply_tick   = 1'b0;
                                end else begin
                                    running_next = 1'b1;
                                    presc_next   = '0;
                                end
                            end
                            T_B: begin
                                if (lap_hold_reg) begin
                                    lap_hold_next = 1'b0;
                                end else if (running_reg) begin
                                    lap_next      = count_vec;
                                    lap_hold_next = 1'b1;
                                end
                            end
                            T_C: begin
                                if (!running_reg) begin
                                    count_load    = 1'b1;
                                    lap_hold_next = 1'b0;
                                    presc_next    = '0;
                                end
                            end
                            T_D: begin
                                mode_next     = SET;
                                running_next  = 1'b0;
                                lap_hold_next = 1'b0;
                                apply_tick    = 1'b0;
                            end
                            default: ;
                        endcase
                    end
                    SET: begin
                        if (k_q_reg <= T_9) begin
                            preset_next = {preset_reg[W-5:0], k_q_reg[3:0]};
                        end else begin
                            case (k_q_reg)
                                T_C: preset_next = '0;
                                T_HASH: begin
                                    count_load     = 1'b1;
                                    count_load_val = preset_reg;
                                    mode_next      = DOWN;
                                    running_next   = 1'b0;
                                end
                                T_ASTE, T_D: mode_next = UP;
                                default: ;
                            endcase
                        end
                    end
                    DOWN: begin
                        case (k_q_reg)
                            T_A: begin
                                if (running_reg) begin
                                    running_next = 1'b0;
                                    apply_tick   = 1'b0;
                                end else if (!count_zero_dn) begin
                                    running_next = 1'b1;
                                    presc_next   = '0;
                                end
                            end
                            T_C: begin
                                if (!running_reg) begin
                                    count_load     = 1'b1;
                                    count_load_val = preset_reg;
                                    presc_next     = '0;
                                end
                            end
                            T_D: begin
                                mode_next    = UP;
                                running_next = 1'b0;
                                alarm_next   = 1'b0;
                                apply_tick   = 1'b0;
                            end
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
        end

        // Decrementing from 1 lands on zero: stop and raise the alarm together.
        if (apply_tick && (mode_reg == DOWN) && (count_vec == COUNT_ONE)) begin
            running_next = 1'b0;
            alarm_next   = 1'b1;
        end

        if (mode_reg == SET) begin
            bcd_next = preset_reg;
        end else if (lap_hold_reg) begin
            bcd_next = lap_reg;
        end else begin
            bcd_next = count_vec;
        end
    end

    assign count_up   = (mode_reg == UP);
    assign count_step = apply_tick && (mode_reg != SET);

    always_ff @(posedge clk) begin
        if (rst) begin
            k_q_reg      <= T_NULL;
            k_prev_reg   <= T_NULL;
            mode_reg     <= UP;
            running_reg  <= 1'b0;
            lap_hold_reg <= 1'b0;
            alarm_reg    <= 1'b0;
            preset_reg   <= '0;
            lap_reg      <= '0;
            presc_reg    <= '0;
            bcd_reg      <= '0;
        end else begin
            k_q_reg      <= key;
            k_prev_reg   <= k_q_reg;
            mode_reg     <= mode_next;
            running_reg  <= running_next;
            lap_hold_reg <= lap_hold_next;
            alarm_reg    <= alarm_next;
            preset_reg   <= preset_next;
            lap_reg      <= lap_next;
            presc_reg    <= presc_next;
            bcd_reg      <= bcd_next;
        end
    end

    // The chain always starts enabled, so in countdown direction its far end
    // reports that every digit is already zero.
    assign carry[0]      = 1'b1;
    assign count_zero_dn = carry[N_DIG];

    generate
        for (genvar gi = 0; gi < N_DIG; gi++) begin : g_dig
            logic [6:0] pat;

            bcd_digito u_digito (
                .clk       (clk),
                .rst       (rst),
                .load      (count_load),
                .load_val  (count_load_val[4*gi +: 4]),
                .tick      (count_step),
                .up        (count_up),
                .carry_in  (carry[gi]),
                .q         (count_vec[4*gi +: 4]),
                .carry_out (carry[gi+1])
            );

            assign pat             = bcd_to_seg(bcd_reg[4*gi +: 4]);
            assign seg[7*gi +: 7]  = (SEG_ACT_LOW != 0) ? ~pat : pat;
        end
    endgenerate

    assign bcd      = bcd_reg;
    assign modo     = mode_reg;
    assign running  = running_reg;
    assign lap_hold = lap_hold_reg;
    assign alarm    = alarm_reg;

endmodule

// File: tb/tb_cronometro_multimodo.sv
// Directed and randomized keypad stimulus checked every cycle against an
// integer-valued behavioural model of the stopwatch.
module tb_cronometro_multimodo;

    localparam int CLK_HZ      = 1000;
    localparam int TICK_HZ     = 10;
    localparam int N_DIG       = 4;
    localparam int SEG_ACT_LOW = 1;
    localparam int DIV         = CLK_HZ / TICK_HZ;
    localparam int MODV        = 10 ** N_DIG;

    localparam int K_A = 10, K_B = 11, K_C = 12, K_D = 13, K_ASTE = 14, K_HASH = 15, K_NULL = 31;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [4:0]         key = 5'd31;
    logic [4*N_DIG-1:0] bcd;
    logic [7*N_DIG-1:0] seg;
    logic [1:0]         modo;
    logic               running;
    logic               lap_hold;
    logic               alarm;

    cronometro_multimodo #(
        .CLK_HZ      (CLK_HZ),
        .TICK_HZ     (TICK_HZ),
        .N_DIG       (N_DIG),
        .SEG_ACT_LOW (SEG_ACT_LOW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key      (key),
        .bcd      (bcd),
        .seg      (seg),
        .modo     (modo),
        .running  (running),
        .lap_hold (lap_hold),
        .alarm    (alarm)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: values held as plain integers (count, preset, lap in decimal).
    int m_count, m_preset, m_lap, m_mode, m_presc, m_kq, m_kp, m_disp;
    bit m_run, m_lh, m_alarm;

    function automatic logic [4*N_DIG-1:0] to_bcd(input int v);
        logic [4*N_DIG-1:0] r;
        int p;
        p = 1;
        for (int i = 0; i < N_DIG; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            default: return 7'b1101111;
        endcase
    endfunction

    function automatic logic [7*N_DIG-1:0] exp_seg(input int v);
        logic [7*N_DIG-1:0] r;
        int p;
        p = 1;
        for (int i = 0; i < N_DIG; i++) begin
            r[7*i +: 7] = (SEG_ACT_LOW != 0) ? ~seg_of((v / p) % 10) : seg_of((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic model_edge(input bit r, input int k);
        bit press, tick, do_tick;
        int old_mode, n_presc;
        if (r) begin
            m_count = 0; m_preset = 0; m_lap = 0; m_mode = 0; m_presc = 0;
            m_run = 0; m_lh = 0; m_alarm = 0; m_kq = K_NULL; m_kp = K_NULL; m_disp = 0;
            return;
        end
        m_disp   = (m_mode == 1) ? m_preset : (m_lh ? m_lap : m_count);
        press    = (m_kp == K_NULL) && (m_kq < 16);
        tick     = m_run && (m_presc == DIV - 1);
        do_tick  = tick;
        old_mode = m_mode;
        n_presc  = m_run ? ((m_presc == DIV - 1) ? 0 : m_presc + 1) : m_presc;
        if (press) begin
            if (m_alarm) begin
                m_alarm = 0;
            end else if (m_mode == 0) begin
                if (m_kq == K_A) begin
                    if (m_run) begin m_run = 0; do_tick = 0; end
                    else begin m_run = 1; n_presc = 0; end
                end else if (m_kq == K_B) begin
                    if (m_lh) m_lh = 0;
                    else if (m_run) begin m_lap = m_count; m_lh = 1; end
                end else if (m_kq == K_C) begin
                    if (!m_run) begin m_count = 0; m_lh = 0; n_presc = 0; end
                end else if (m_kq == K_D) begin
                    m_mode = 1; m_run = 0; m_lh = 0; do_tick = 0;
                end
            end else if (m_mode == 1) begin
                if (m_kq <= 9) m_preset = (m_preset * 10 + m_kq) % MODV;
                else if (m_kq == K_C) m_preset = 0;
                else if (m_kq == K_HASH) begin m_count = m_preset; m_mode = 2; m_run = 0; end
                else if (m_kq == K_ASTE || m_kq == K_D) m_mode = 0;
            end else begin
                if (m_kq == K_A) begin
                    if (m_run) begin m_run = 0; do_tick = 0; end
                    else if (m_count != 0) begin m_run = 1; n_presc = 0; end
                end else if (m_kq == K_C) begin
                    if (!m_run) begin m_count = m_preset; n_presc = 0; end
                end else if (m_kq == K_D) begin
                    m_mode = 0; m_run = 0; m_alarm = 0; do_tick = 0;
                end
            end
        end
        if (do_tick) begin
            if (old_mode == 0) begin
                m_count = (m_count + 1) % MODV;
            end else if (old_mode == 2 && m_count > 0) begin
                m_count = m_count - 1;
                if (m_count == 0) begin m_run = 0; m_alarm = 1; end
            end
        end
        m_presc = n_presc;
        m_kp    = m_kq;
        m_kq    = k;
    endtask

    task automatic step(input int k, input bit r);
        @(negedge clk);
        key = k[4:0];
        rst = r;
        @(posedge clk);
        model_edge(r, k);
        #1;
        check_val("bcd",      bcd,      to_bcd(m_disp));
        check_val("seg",      seg,      exp_seg(m_disp));
        check_val("modo",     modo,     m_mode);
        check_val("running",  running,  m_run);
        check_val("lap_hold", lap_hold, m_lh);
        check_val("alarm",    alarm,    m_alarm);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(K_NULL, 0);
    endtask

    task automatic press_key(input int k, input int hold);
        for (int i = 0; i < hold; i++) step(k, 0);
        step(K_NULL, 0);
        step(K_NULL, 0);
        $display("press key=%0d hold=%0d -> modo=%0d bcd=%h run=%0b lap=%0b alarm=%0b",
                 k, hold, modo, bcd, running, lap_hold, alarm);
    endtask

    initial begin
        step(K_NULL, 1);
        step(K_NULL, 1);
        check_val("reset_bcd", bcd, 16'h0000);
        check_val("reset_seg", seg, {4{7'h40}});
        check_val("reset_run", running, 1'b0);

        // Start, count, stop, clear
        press_key(K_A, 1);
        idle(1000);
        check_val("count_1s", bcd, 16'h0010);
        press_key(K_A, 1);
        idle(50);
        check_val("frozen", bcd, 16'h0010);
        check_val("stopped", running, 1'b0);
        press_key(K_C, 1);
        check_val("cleared", bcd, 16'h0000);

        // Lap hold
        press_key(K_A, 1);
        idle(2500);
        press_key(K_B, 1);
        check_val("lap_set", lap_hold, 1'b1);
        check_val("lap_val", bcd, 16'h0025);
        idle(1000);
        check_val("lap_frozen", bcd, 16'h0025);
        press_key(K_B, 1);
        check_val("lap_release", bcd, 16'h0035);
        press_key(K_A, 1);
        press_key(K_C, 1);

        // Wrap from 9998
        press_key(K_D, 1);
        press_key(9, 1); press_key(9, 1); press_key(9, 1); press_key(8, 1);
        press_key(K_HASH, 1);
        check_val("preload", bcd, 16'h9998);
        press_key(K_D, 1);
        press_key(K_A, 1);
        idle(200);
        check_val("wrap_val", bcd, 16'h0000);
        check_val("wrap_run", running, 1'b1);
        press_key(K_A, 1);
        press_key(K_C, 1);

        // Countdown with alarm
        press_key(K_D, 1);
        press_key(0, 1); press_key(0, 1); press_key(1, 1); press_key(2, 1);
        press_key(K_HASH, 1);
        check_val("down_mode", modo, 2'd2);
        check_val("down_val", bcd, 16'h0012);
        press_key(K_A, 1);
        idle(1200);
        check_val("down_zero", bcd, 16'h0000);
        check_val("down_stop", running, 1'b0);
        check_val("alarm_on", alarm, 1'b1);
        press_key(K_A, 1);
        check_val("alarm_off", alarm, 1'b0);
        check_val("alarm_norun", running, 1'b0);
        press_key(K_D, 1);

        // Long hold is one press; key change without NULL is not a press
        press_key(K_A, 500);
        check_val("hold_single", running, 1'b1);
        press_key(K_A, 1);
        step(K_A, 0);
        step(K_B, 0); step(K_B, 0); step(K_B, 0);
        idle(2);
        check_val("chg_run", running, 1'b1);
        check_val("chg_nolap", lap_hold, 1'b0);

        // Reset mid-run
        idle(150);
        step(K_NULL, 1);
        check_val("rst_bcd", bcd, 16'h0000);
        check_val("rst_modo", modo, 2'd0);
        check_val("rst_run", running, 1'b0);
        check_val("rst_seg", seg, {4{7'h40}});

        // Stop press landing on the first tick edge discards that tick
        press_key(K_A, 1);
        idle(97);
        step(K_A, 0);
        step(K_NULL, 0);
        step(K_NULL, 0);
        check_val("coll_run", running, 1'b0);
        check_val("coll_val", bcd, 16'h0000);
        idle(150);
        check_val("coll_hold", bcd, 16'h0000);

        // Randomized keypad traffic
        for (int t = 0; t < 300; t++) begin
            int k, hold;
            if ($urandom_range(0, 99) < 2) begin
                step(K_NULL, 1);
            end else begin
                k = $urandom_range(0, 18);
                if (k > 15) k = $urandom_range(16, 30);
                hold = $urandom_range(1, 4);
                for (int i = 0; i < hold; i++) step(k, 0);
                if ($urandom_range(0, 7) == 0) step($urandom_range(0, 15), 0);
                press_key(K_NULL, 0);
            end
            idle($urandom_range(1, 200));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
